instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Upstream feeder for the 16-bit bus processor.
- Holds a small loadable program memory and walks a program counter through it.
- Presents each instruction word on the processor's Din with a one-cycle run pulse, then waits for the processor's done.
- For mvi it supplies the following immediate word as well, and it flags a hung processor with a watchdog.

Parameters:
- WORD, 16, data width; equals processor word width.
- DEPTH, 16, program memory entries; power of two.
- AW, 4, address width, log2(DEPTH).
- TIMEOUT, 15, max cycles in WAIT before error; must be ≥ 2 and < 2^8.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- prog_we  in  1  program memory write strobe.
- prog_addr  in  AW  write address.
- prog_data  in  WORD  write data.
- prog_len  in  AW+1  number of valid words, 0..DEPTH; sampled on start.
- start  in  1  begin execution at address 0.
- abort  in  1  stop execution; return to IDLE.
- cpu_done  in  1  processor done.
- cpu_din  out  WORD  word to processor Din.
- cpu_run  out  1  processor run.
- busy  out  1  high in ISSUE or WAIT.
- finished  out  1  program completed; sticky.
- error  out  1  watchdog expired; sticky.
- pc  out  AW  current program counter.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; pc=0; len_q=0; wd=0.
  - cpu_run=0, busy=0, finished=0, error=0.
  - cpu_din=0 while in IDLE.
  - Memory contents are not reset.
- Opcode field:
  - Instruction bits [8:6].
  - OP_MVI=3'b001 consumes two words; every other opcode consumes one.
- Memory:
  - DEPTH x WORD register array with combinational read.
  - Writes take effect next edge, accepted only in IDLE, FINISH or ERROR.
  - prog_we is ignored while busy.
- IDLE:
  - Outputs low.
  - start=1 with prog_len≠0: latch len_q=prog_len, pc=0, clear finished/error, go to ISSUE.
  - start=1 with prog_len=0: go straight to FINISH; finished=1 next cycle.
- ISSUE (exactly 1 cycle):
  - cpu_run=1, cpu_din=mem[pc].
  - Latch is_mvi from mem[pc][8:6], clear wd, go to WAIT.
- WAIT:
  - cpu_run=0.
  - cpu_din=mem[(pc+1) mod DEPTH] if is_mvi, else mem[pc]. The value is held stable every cycle until done.
  - wd increments each cycle.
  - cpu_done=1 in this state:
    - pc_next = pc + (is_mvi ? 2 : 1), computed in AW+1 bits.
    - If pc_next ≥ len_q, go to FINISH (pc holds its last value).
    - Otherwise pc=pc_next and go to ISSUE. Result: one idle gap cycle between done and the next run.
  - cpu_done=0 and wd==TIMEOUT-1: go to ERROR.
  - cpu_done and timeout in the same cycle: done wins.
- FINISH:
  - finished=1, busy=0.
  - start restarts as in IDLE (finished drops the cycle ISSUE is entered).
- ERROR:
  - error=1.
  - Left only by abort (to IDLE) or reset; start is ignored.
- abort:
  - In any state, go to IDLE next cycle with all outputs low and finished/error cleared.
  - Takes priority over start and cpu_done.
  - Does not reset the processor; the integrator pulses the processor resetn separately.
- mvi in the last slot (pc=len_q-1): the immediate is read from the wrapped address pc+1 mod DEPTH. Completion still goes to FINISH.
- cpu_done seen in IDLE, ISSUE, FINISH or ERROR is ignored.
- Output derivation: cpu_run and busy decode from the state register only. cpu_din depends on state, pc, is_mvi and memory.

Decomposition:
- Package instr_seq_pkg holds:
  - state encoding: IDLE, ISSUE, WAIT, FINISH, ERROR;
  - OP_MVI;
  - opcode field bounds [8:6].
- One sub-module, prog_mem (register array, sync write, async read), instanced inside. The FSM, pc and watchdog stay in instr_sequencer.

Test Plan:
- Load mem[0]=0x0040 (mvi R0), mem[1]=0x0005, mem[2]=0x0088 (add R2,R0), prog_len=3, start. Respond with done 3 cycles after each run.
  - Required: run pulses at pc=0 and pc=2 only.
  - Required: cpu_din=0x0005 throughout the first WAIT.
  - Required: finished=1 after the second done, and pc=2.
- prog_len=0, start → finished=1 next cycle, and cpu_run never asserts.
- Hold cpu_done=0 with TIMEOUT=15 → error=1 exactly 15 cycles after WAIT entry. Then start is ignored, and abort returns to IDLE with error=0.
- Assert abort mid-WAIT together with cpu_done → IDLE next cycle, pc=0, run stays low, finished=0.
- Write prog_addr=1 while busy → mem[1] unchanged. The same write in FINISH → mem[1] updated, and a restart issues the new word.
- Reset mid-WAIT, async and between edges → outputs drop immediately. After release the block sits in IDLE, and memory retains its contents on restart.

Source files
------------

// File: rtl/instr_seq_pkg.sv
// Shared definitions for the instruction sequencer.
// Holds the FSM state encoding and the opcode field layout. The sequencer
// needs the opcode only to recognise mvi, which carries an immediate word.
package instr_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_FINISH,
    S_ERROR
  } seq_state_t;

  // Opcode field position within an instruction word
  localparam int unsigned OP_MSB = 8;
  localparam int unsigned OP_LSB = 6;

  // mvi is the only opcode that is followed by an immediate word
  localparam logic [OP_MSB-OP_LSB:0] OP_MVI = 3'b001;

endpackage

// File: rtl/instr_sequencer_prog_mem.sv
// Program memory for the instruction sequencer.
// DEPTH x WORD register array with a synchronous write port and an
// asynchronous (combinational) read port. Contents are not reset.
// Ports:
//   clk    - write clock
//   we     - write enable (gated by the caller)
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data, combinational from raddr
module prog_mem #(
  parameter int unsigned WORD  = 16,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [WORD-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [WORD-1:0] rdata
);

  logic [WORD-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: upstream feeder for the 16-bit bus processor.
// Walks a program counter through a loadable program memory, presents each
// instruction on the processor's Din with a one-cycle run pulse, then waits
// for done. For mvi the immediate word (next address, wrapping) is presented
// during the wait. A watchdog flags a processor that never answers.
// Ports:
//   clk, resetn          - clock, asynchronous active-low reset
//   prog_we/addr/data    - program memory write port (ignored while busy)
//   prog_len             - number of valid words, sampled on start
//   start                - begin execution at address 0
//   abort                - return to IDLE from any state (highest priority)
//   cpu_done             - processor done
//   cpu_din, cpu_run     - word and run strobe to the processor
//   busy                 - in ISSUE or WAIT
//   finished, error      - program complete / watchdog expired (sticky)
//   pc                   - current program counter
module instr_sequencer
  import instr_seq_pkg::*;
#(
  parameter int unsigned WORD    = 16,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            prog_we,
  input  logic [AW-1:0]   prog_addr,
  input  logic [WORD-1:0] prog_data,
  input  logic [AW:0]     prog_len,
  input  logic            start,
  input  logic            abort,
  input  logic            cpu_done,
  output logic [WORD-1:0] cpu_din,
  output logic            cpu_run,
  output logic            busy,
  output logic            finished,
  output logic            error,
  output logic [AW-1:0]   pc
);

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  seq_state_t      state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [AW:0]     len_q, len_d;
  logic [7:0]      wd_q, wd_d;
  logic            is_mvi_q, is_mvi_d;

  logic [AW-1:0]   rd_addr;
  logic [WORD-1:0] rd_data;
  logic [AW:0]     pc_next;
  logic            mem_we;

  // Writes are accepted whenever the sequencer is not executing
  assign mem_we = prog_we && !busy;

  // Single read port: the immediate address wraps naturally in AW bits
  assign rd_addr = (state_q == S_WAIT && is_mvi_q) ? pc_q + AW'(1) : pc_q;

  prog_mem #(
    .WORD (WORD),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_prog_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(prog_addr),
    .wdata(prog_data),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  // Computed one bit wider so a step past the last entry never wraps
  assign pc_next = {1'b0, pc_q} + (is_mvi_q ? (AW+1)'(2) : (AW+1)'(1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      len_q    <= '0;
      wd_q     <= '0;
      is_mvi_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      len_q    <= len_d;
      wd_q     <= wd_d;
      is_mvi_q <= is_mvi_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    len_d    = len_q;
    wd_d     = wd_q;
    is_mvi_d = is_mvi_q;

    unique case (state_q)
      S_IDLE, S_FINISH: begin
        if (start) begin
          pc_d = '0;
          if (prog_len != '0) begin
            len_d   = prog_len;
            state_d = S_ISSUE;
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_ISSUE: begin
        is_mvi_d = (rd_data[OP_MSB:OP_LSB] == OP_MVI);
        wd_d     = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        wd_d = wd_q + 8'd1;
        // done beats a simultaneous watchdog expiry
        if (cpu_done) begin
          if (pc_next >= len_q) begin
            state_d = S_FINISH;
          end else begin
            pc_d    = pc_next[AW-1:0];
            state_d = S_ISSUE;
          end
        end else if (wd_q == WD_LAST) begin
          state_d = S_ERROR;
        end
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort) begin
      state_d = S_IDLE;
      pc_d    = '0;
    end
  end

  // finished/error are sticky by virtue of living in their own states
  assign cpu_run  = (state_q == S_ISSUE);
  assign busy     = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign finished = (state_q == S_FINISH);
  assign error    = (state_q == S_ERROR);
  assign pc       = pc_q;
  assign cpu_din  = busy ? rd_data : '0;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed testbench for instr_sequencer with hand-computed expectations.
module tb_instr_sequencer;

  localparam int unsigned WORD = 16;
  localparam int unsigned AW   = 4;

  logic            clk;
  logic            resetn;
  logic            prog_we;
  logic [AW-1:0]   prog_addr;
  logic [WORD-1:0] prog_data;
  logic [AW:0]     prog_len;
  logic            start;
  logic            abort;
  logic            cpu_done;
  logic [WORD-1:0] cpu_din;
  logic            cpu_run;
  logic            busy;
  logic            finished;
  logic            error;
  logic [AW-1:0]   pc;

  int unsigned n_tests;
  int unsigned n_fail;
  int unsigned run_cnt;
  logic [15:0] run_pc_mask;

  instr_sequencer #(
    .WORD   (16),
    .DEPTH  (16),
    .AW     (4),
    .TIMEOUT(15)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .prog_we  (prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .prog_len (prog_len),
    .start    (start),
    .abort    (abort),
    .cpu_done (cpu_done),
    .cpu_din  (cpu_din),
    .cpu_run  (cpu_run),
    .busy     (busy),
    .finished (finished),
    .error    (error),
    .pc       (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Run pulse monitor, sampled on the inactive edge
  always @(negedge clk) begin
    if (cpu_run) begin
      run_cnt++;
      run_pc_mask[pc] = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [WORD-1:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic start_prog(input logic [AW:0] len);
    prog_len = len; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench time limit");
  end

  initial begin
    n_tests = 0; n_fail = 0; run_cnt = 0; run_pc_mask = '0;
    resetn = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    prog_len = '0; start = 1'b0; abort = 1'b0; cpu_done = 1'b0;

    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_run", 32'(cpu_run), 32'd0);
    chk("rst_fin", 32'(finished), 32'd0);
    chk("rst_err", 32'(error), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_din", 32'(cpu_din), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    tick();

    // T1: mvi R0,#5 ; add R2,R0 -- done 3 cycles after each run
    load(4'd0, 16'h0040);
    load(4'd1, 16'h0005);
    load(4'd2, 16'h0088);
    run_cnt = 0; run_pc_mask = '0;
    start_prog(5'd3);
    chk("t1_run0", 32'(cpu_run), 32'd1);
    chk("t1_pc0", 32'(pc), 32'd0);
    chk("t1_din_issue0", 32'(cpu_din), 32'h0040);
    tick();
    chk("t1_run_wait", 32'(cpu_run), 32'd0);
    chk("t1_busy_wait", 32'(busy), 32'd1);
    chk("t1_imm_c1", 32'(cpu_din), 32'h0005);
    tick();
    chk("t1_imm_c2", 32'(cpu_din), 32'h0005);
    tick();
    chk("t1_imm_c3", 32'(cpu_din), 32'h0005);
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    chk("t1_run2", 32'(cpu_run), 32'd1);
    chk("t1_pc2", 32'(pc), 32'd2);
    chk("t1_din_issue2", 32'(cpu_din), 32'h0088);
    tick();
    chk("t1_din_wait2", 32'(cpu_din), 32'h0088);
    tick();
    tick();
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    chk("t1_fin", 32'(finished), 32'd1);
    chk("t1_fin_pc", 32'(pc), 32'd2);
    chk("t1_fin_busy", 32'(busy), 32'd0);
    chk("t1_fin_din", 32'(cpu_din), 32'd0);
    tick();
    chk("t1_fin_sticky", 32'(finished), 32'd1);
    chk("t1_run_cnt", run_cnt, 32'd2);
    chk("t1_run_pcs", 32'(run_pc_mask), 32'h0005);

    // T2: abort from FINISH, then zero-length program
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t2_abort_fin", 32'(finished), 32'd0);
    chk("t2_abort_busy", 32'(busy), 32'd0);
    run_cnt = 0;
    start_prog(5'd0);
    chk("t2_len0_fin", 32'(finished), 32'd1);
    chk("t2_len0_busy", 32'(busy), 32'd0);
    tick();
    chk("t2_len0_runs", run_cnt, 32'd0);

    // T3: watchdog -- error exactly 15 cycles after WAIT entry
    start_prog(5'd3);
    chk("t3_fin_drop", 32'(finished), 32'd0);
    chk("t3_issue", 32'(cpu_run), 32'd1);
    tick();
    for (int i = 0; i < 14; i++) tick();
    chk("t3_err_early", 32'(error), 32'd0);
    chk("t3_busy_14", 32'(busy), 32'd1);
    tick();
    chk("t3_err_15", 32'(error), 32'd1);
    chk("t3_err_busy", 32'(busy), 32'd0);
    start_prog(5'd3);
    chk("t3_start_ign_err", 32'(error), 32'd1);
    chk("t3_start_ign_run", 32'(cpu_run), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t3_abort_err", 32'(error), 32'd0);
    chk("t3_abort_busy", 32'(busy), 32'd0);
    chk("t3_abort_pc", 32'(pc), 32'd0);

    // T4: abort together with done mid-WAIT on the last instruction
    start_prog(5'd3);
    tick();
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    chk("t4_pc2", 32'(pc), 32'd2);
    tick();
    run_cnt = 0;
    abort = 1'b1; cpu_done = 1'b1;
    tick();
    abort = 1'b0; cpu_done = 1'b0;
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_pc", 32'(pc), 32'd0);
    chk("t4_fin", 32'(finished), 32'd0);
    chk("t4_din", 32'(cpu_din), 32'd0);
    tick();
    chk("t4_no_run", run_cnt, 32'd0);

    // T5: write while busy is dropped; write in FINISH lands
    start_prog(5'd3);
    tick();
    prog_we = 1'b1; prog_addr = 4'd1; prog_data = 16'h1234;
    tick();
    prog_we = 1'b0;
    chk("t5_busy_write", 32'(cpu_din), 32'h0005);
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    tick();
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    chk("t5_fin", 32'(finished), 32'd1);
    load(4'd1, 16'h0077);
    start_prog(5'd3);
    chk("t5_restart_din", 32'(cpu_din), 32'h0040);
    tick();
    chk("t5_new_imm", 32'(cpu_din), 32'h0077);
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    tick();

    // T6: asynchronous reset between edges while in WAIT
    #3;
    resetn = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_run", 32'(cpu_run), 32'd0);
    chk("t6_din", 32'(cpu_din), 32'd0);
    chk("t6_pc", 32'(pc), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    chk("t6_idle", 32'(busy), 32'd0);
    start_prog(5'd3);
    chk("t6_mem0", 32'(cpu_din), 32'h0040);
    tick();
    chk("t6_mem1", 32'(cpu_din), 32'h0077);
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    chk("t6_mem2", 32'(cpu_din), 32'h0088);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
